// File: rtl/tl_bram_bridge_pkg.sv
// tl_bram_pkg: shared types and constants for the TileLink-UL to BRAM bridge.
//   a_opcode_e  request opcodes the bridge accepts
//   d_opcode_e  response opcodes the bridge produces
//   rsp_t       one response-queue entry
//   req_legal() decides whether a request is issued or denied
package tl_bram_pkg;

  localparam int MAX_SIZE          = 3;   // 8-byte beat is the widest transfer
  localparam int MAX_SOURCE_WIDTH  = 8;   // rsp_t carries up to this many ID bits
  localparam int DATA_WIDTH        = 64;
  localparam int MASK_WIDTH        = 8;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef struct packed {
    d_opcode_e                   opcode;
    logic [MAX_SOURCE_WIDTH-1:0] source;
    logic                        denied;
    logic [DATA_WIDTH-1:0]       data;
  } rsp_t;

  function automatic logic req_legal(input logic [2:0] opcode, input logic [2:0] size);
    return (size <= 3'(MAX_SIZE)) &&
           (opcode == A_PUT_FULL || opcode == A_PUT_PARTIAL || opcode == A_GET);
  endfunction

endpackage

// File: rtl/tl_bram_bridge_if.sv
// tl_bram_bridge_if: TileLink-UL A (request) and D (response) channels.
//   master modport: interconnect side (drives A, consumes D)
//   slave  modport: bridge side (consumes A, drives D)
interface tl_bram_bridge_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int SOURCE_WIDTH = 4
);
  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_size;
  logic [SOURCE_WIDTH-1:0] a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [7:0]              a_mask;
  logic [63:0]             a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [2:0]              d_opcode;
  logic [SOURCE_WIDTH-1:0] d_source;
  logic                    d_denied;
  logic [63:0]             d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_denied, d_data
  );
endinterface

// File: rtl/tl_bram_bridge_sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
//   clk, rst      clock, synchronous active-high reset (empties the queue)
//   push_i        write push_data_i at the tail
//   pop_i         drop the head entry
//   head_o        head entry, read straight from storage; a push into an
//                 empty queue shows up here the following cycle (no bypass)
//   count_o       number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && !pop_i && count_q == CNT_W'(DEPTH)))
        else $error("sync_fifo: push into a full queue");
      assert (!(pop_i && count_q == '0))
        else $error("sync_fifo: pop from an empty queue");
    end
  end
`endif
endmodule

// File: rtl/tl_bram_bridge.sv
// tl_bram_bridge: TileLink-UL slave port to 1-cycle-latency BRAM master port.
//   clk, rst     clock, synchronous active-high reset
//   tl           A/D channels (slave modport)
//   bram_addr    byte address, valid while bram_en
//   bram_en      access strobe, asserted in the request accept cycle
//   bram_we      byte write enables (0 for reads)
//   bram_wrdata  write data
//   bram_rddata  read data, one cycle after bram_en
// Requests are issued to the BRAM in their accept cycle; the response is
// assembled one cycle later when read data arrives and queued in order.
// SOURCE_WIDTH must not exceed tl_bram_pkg::MAX_SOURCE_WIDTH.
module tl_bram_bridge
  import tl_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int SOURCE_WIDTH = 4,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tl_bram_bridge_if.slave       tl,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [7:0]            bram_we,
  output logic [63:0]           bram_wrdata,
  input  logic [63:0]           bram_rddata
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic                    accept, legal, is_get, issue, pop;
  logic                    inflight_q, inflight_d;
  logic                    cap_get_q, cap_get_d;
  d_opcode_e               cap_opcode_q, cap_opcode_d;
  logic [SOURCE_WIDTH-1:0] cap_source_q, cap_source_d;
  logic                    cap_denied_q, cap_denied_d;
  logic [CW-1:0]           rsp_count;
  logic [CW:0]             credit_used;
  rsp_t                    push_rsp, head_rsp;
  logic                    unused_head_source;

  // Credit counts queued responses plus the one still waiting for read data,
  // so every accepted request has a queue slot reserved. Built only from
  // registers so a_ready has no combinational path from a_* or d_ready.
  assign credit_used = {1'b0, rsp_count} + {{CW{1'b0}}, inflight_q};
  assign tl.a_ready  = !rst && (credit_used < (CW + 1)'(RSP_DEPTH));

  assign accept = tl.a_valid && tl.a_ready;
  assign legal  = req_legal(tl.a_opcode, tl.a_size);
  assign is_get = (tl.a_opcode == A_GET);
  assign issue  = accept && legal;

  assign bram_en     = issue;
  assign bram_we     = (issue && !is_get) ? tl.a_mask : '0;
  assign bram_addr   = tl.a_address;
  assign bram_wrdata = tl.a_data;

  // Only a Get earns AccessAckData; every other opcode, legal or not, is
  // answered with a plain AccessAck.
  always_comb begin
    inflight_d   = accept;
    cap_get_d    = cap_get_q;
    cap_opcode_d = cap_opcode_q;
    cap_source_d = cap_source_q;
    cap_denied_d = cap_denied_q;
    if (accept) begin
      cap_get_d    = legal && is_get;
      cap_opcode_d = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      cap_source_d = tl.a_source;
      cap_denied_d = !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      cap_get_q    <= 1'b0;
      cap_opcode_q <= D_ACCESS_ACK;
      cap_source_q <= '0;
      cap_denied_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      cap_get_q    <= cap_get_d;
      cap_opcode_q <= cap_opcode_d;
      cap_source_q <= cap_source_d;
      cap_denied_q <= cap_denied_d;
    end
  end

  always_comb begin
    push_rsp.opcode = cap_opcode_q;
    push_rsp.source = MAX_SOURCE_WIDTH'(cap_source_q);
    push_rsp.denied = cap_denied_q;
    push_rsp.data   = cap_get_q ? bram_rddata : '0;
  end

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .head_o      (head_rsp),
    .count_o     (rsp_count)
  );

  // Response fields are forced to zero while idle so stale queue storage
  // never leaks onto the D channel.
  assign tl.d_valid  = (rsp_count != '0);
  assign pop         = tl.d_valid && tl.d_ready;
  assign tl.d_opcode = tl.d_valid ? head_rsp.opcode : D_ACCESS_ACK;
  assign tl.d_source = tl.d_valid ? head_rsp.source[SOURCE_WIDTH-1:0] : '0;
  assign tl.d_denied = tl.d_valid && head_rsp.denied;
  assign tl.d_data   = tl.d_valid ? head_rsp.data : '0;

  assign unused_head_source = ^head_rsp.source;
endmodule

// File: tb/tb_tl_bram_bridge.sv
module tb_tl_bram_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bram_addr;
  logic        bram_en;
  logic [7:0]  bram_we;
  logic [63:0] bram_wrdata;
  logic [63:0] bram_rddata = '0;

  int checks = 0;
  int errors = 0;

  tl_bram_bridge_if #(.ADDR_WIDTH(16), .SOURCE_WIDTH(4)) tl ();

  tl_bram_bridge #(.ADDR_WIDTH(16), .SOURCE_WIDTH(4), .RSP_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tl          (tl),
    .bram_addr   (bram_addr),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_wrdata (bram_wrdata),
    .bram_rddata (bram_rddata)
  );

  always #5 clk = ~clk;

  // BRAM contents as seen by reads: 0x4000 holds 0x1234, elsewhere a tag plus address.
  function automatic logic [63:0] mem_val(input logic [15:0] a);
    if (a == 16'h4000) return 64'h1234;
    return 64'hC0DE_0000_0000_0000 | {48'h0, a};
  endfunction

  // Read data appears one cycle after bram_en; writes and idle cycles leave
  // junk on the bus so a bridge that fails to zero write data is caught.
  always @(posedge clk) begin
    if (bram_en && bram_we == 8'h00) bram_rddata <= mem_val(bram_addr);
    else if (bram_en)                bram_rddata <= 64'hBAD0_BAD0_BAD0_BAD0;
    else                             bram_rddata <= 64'hFFFF_EEEE_DDDD_CCCC;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  opc;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [15:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic        exp_en;
    logic [7:0]  exp_we;
    logic [2:0]  exp_dop;
    logic        exp_den;
    logic [63:0] exp_ddata;
  } vec_t;

  task automatic idle_a();
    tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_size = 3'd0; tl.a_source = '0;
    tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0;
  endtask

  // One isolated request with d_ready high: accept at T, response at T+2, gone at T+3.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    tl.a_valid = 1'b1; tl.a_opcode = v.opc; tl.a_size = v.size; tl.a_source = v.src;
    tl.a_address = v.addr; tl.a_mask = v.mask; tl.a_data = v.wdata;
    #1;
    chk({tag, " a_ready"}, 64'(tl.a_ready), 64'd1);
    chk({tag, " bram_en"}, 64'(bram_en), 64'(v.exp_en));
    chk({tag, " bram_we"}, 64'(bram_we), 64'(v.exp_we));
    if (v.exp_en) chk({tag, " bram_addr"}, 64'(bram_addr), 64'(v.addr));
    if (v.exp_we != 8'h00) chk({tag, " bram_wrdata"}, bram_wrdata, v.wdata);
    @(negedge clk);
    idle_a();
    #1;
    chk({tag, " d_valid T+1"}, 64'(tl.d_valid), 64'd0);
    chk({tag, " bram_en T+1"}, 64'(bram_en), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, " d_valid T+2"}, 64'(tl.d_valid), 64'd1);
    chk({tag, " d_opcode"}, 64'(tl.d_opcode), 64'(v.exp_dop));
    chk({tag, " d_source"}, 64'(tl.d_source), 64'(v.src));
    chk({tag, " d_denied"}, 64'(tl.d_denied), 64'(v.exp_den));
    chk({tag, " d_data"}, tl.d_data, v.exp_ddata);
    @(negedge clk);
    #1;
    chk({tag, " d_valid T+3"}, 64'(tl.d_valid), 64'd0);
  endtask

  // Stream of n Gets; d_ready is held low until cycle ready_at.
  task automatic run_stream(input int n, input int ready_at);
    logic [3:0]  src_q[$];
    logic [63:0] dat_q[$];
    logic [15:0] a;
    int sent = 0, rcvd = 0, cyc = 0, acc_blocked = 0;
    while (rcvd < n && cyc < 200) begin
      @(negedge clk);
      tl.d_ready = (cyc >= ready_at);
      idle_a();
      a = 16'h0100 + 16'(sent * 8);
      if (sent < n) begin
        tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_size = 3'd3;
        tl.a_source = 4'(sent); tl.a_address = a;
      end
      #1;
      if (ready_at == 0 && sent < n) chk("stream a_ready", 64'(tl.a_ready), 64'd1);
      if (tl.a_valid && tl.a_ready) begin
        chk("stream bram_en", 64'(bram_en), 64'd1);
        chk("stream bram_addr", 64'(bram_addr), 64'(a));
        chk("stream bram_we", 64'(bram_we), 64'd0);
        src_q.push_back(4'(sent));
        dat_q.push_back(mem_val(a));
        sent++;
        if (!tl.d_ready) acc_blocked++;
      end else begin
        chk("stream idle bram_en", 64'(bram_en), 64'd0);
      end
      if (tl.d_valid) begin
        if (src_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream extra response: got source %0d expected none", tl.d_source);
        end else begin
          chk("stream d_source", 64'(tl.d_source), 64'(src_q[0]));
          chk("stream d_data", tl.d_data, dat_q[0]);
          chk("stream d_opcode", 64'(tl.d_opcode), 64'd1);
          chk("stream d_denied", 64'(tl.d_denied), 64'd0);
          if (tl.d_ready) begin
            void'(src_q.pop_front());
            void'(dat_q.pop_front());
            rcvd++;
          end
        end
      end
      cyc++;
    end
    idle_a();
    chk("stream responses", 64'(rcvd), 64'(n));
    if (ready_at > 0) chk("accepts while d_ready low", 64'(acc_blocked), 64'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{3'd4, 3'd3, 4'd5,  16'h4000, 8'h00, 64'h0, 1'b1, 8'h00, 3'd1, 1'b0, 64'h1234};
    vecs[1] = '{3'd1, 3'd0, 4'd2,  16'h0000, 8'h01, 64'h1, 1'b1, 8'h01, 3'd0, 1'b0, 64'h0};
    vecs[2] = '{3'd0, 3'd3, 4'd7,  16'h0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 8'hFF, 3'd0, 1'b0, 64'h0};
    vecs[3] = '{3'd0, 3'd3, 4'd9,  16'h0018, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 8'h0F, 3'd0, 1'b0, 64'h0};
    vecs[4] = '{3'd4, 3'd4, 4'd3,  16'h4000, 8'hFF, 64'h0, 1'b0, 8'h00, 3'd1, 1'b1, 64'h0};
    vecs[5] = '{3'd2, 3'd2, 4'd11, 16'h0020, 8'hFF, 64'h5, 1'b0, 8'h00, 3'd0, 1'b1, 64'h0};
    vecs[6] = '{3'd4, 3'd2, 4'd15, 16'h0108, 8'h00, 64'h0, 1'b1, 8'h00, 3'd1, 1'b0, 64'hC0DE_0000_0000_0108};
    vecs[7] = '{3'd5, 3'd0, 4'd1,  16'h0030, 8'h01, 64'h7, 1'b0, 8'h00, 3'd0, 1'b1, 64'h0};
    vecs[8] = '{3'd1, 3'd7, 4'd6,  16'h0038, 8'hFF, 64'h9, 1'b0, 8'h00, 3'd0, 1'b1, 64'h0};
    vecs[9] = '{3'd4, 3'd0, 4'd0,  16'hFFF8, 8'h00, 64'h0, 1'b1, 8'h00, 3'd1, 1'b0, 64'hC0DE_0000_0000_FFF8};

    idle_a();
    tl.d_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset a_ready", 64'(tl.a_ready), 64'd1);
    chk("reset d_valid", 64'(tl.d_valid), 64'd0);
    chk("reset d_opcode", 64'(tl.d_opcode), 64'd0);
    chk("reset d_source", 64'(tl.d_source), 64'd0);
    chk("reset d_denied", 64'(tl.d_denied), 64'd0);
    chk("reset d_data", tl.d_data, 64'd0);
    chk("reset bram_en", 64'(bram_en), 64'd0);
    chk("reset bram_we", 64'(bram_we), 64'd0);

    for (int i = 0; i < 10; i++) apply(vecs[i], i);

    run_stream(16, 0);
    run_stream(6, 10);

    // Reset with three responses queued.
    @(negedge clk);
    tl.d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_size = 3'd3;
      tl.a_source = 4'(8 + i); tl.a_address = 16'h0200 + 16'(i * 8);
      #1;
      chk("pre-reset accept", 64'(tl.a_ready), 64'd1);
    end
    @(negedge clk);
    idle_a();
    repeat (2) @(negedge clk);
    #1;
    chk("pre-reset d_valid", 64'(tl.d_valid), 64'd1);
    chk("pre-reset d_source", 64'(tl.d_source), 64'd8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset d_valid", 64'(tl.d_valid), 64'd0);
    chk("post-reset a_ready", 64'(tl.a_ready), 64'd1);
    chk("post-reset d_data", tl.d_data, 64'd0);
    chk("post-reset d_source", 64'(tl.d_source), 64'd0);
    tl.d_ready = 1'b1;
    apply('{3'd4, 3'd3, 4'd4, 16'h0200, 8'h00, 64'h0, 1'b1, 8'h00, 3'd1, 1'b0, 64'hC0DE_0000_0000_0200}, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
